// File: rtl/pipeline_datapath.sv
// ---------------------------------------------------------------------------
// pipeline_datapath
//
// Fixed-depth, four-stage arithmetic pipeline used to characterise timing.
// One sample enters on every rising clock edge and moves one stage per edge.
// There is no handshake, so the pipeline never stalls.
//
//   stage 1 (r1) : capture in_data
//   stage 2 (r2) : r1 + ADD_K, wrapping modulo 2^WIDTH
//   stage 3 (r3) : r2 * MUL_K, saturating to all-ones on overflow
//   stage 4 (r4) : r3 ^ XOR_K, driven straight onto out_data
//
// A sample captured on edge N appears on out_data after edge N+3.
//
// Ports
//   clk      : single clock; every register updates on its rising edge
//   rst_n    : asynchronous reset, ACTIVE-HIGH despite the _n suffix.
//              While it is 1, all four stages are held at zero.
//   in_data  : sample presented to stage 1 (WIDTH bits)
//   out_data : registered stage-4 result (WIDTH bits)
// ---------------------------------------------------------------------------
module pipeline_datapath #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] ADD_K = WIDTH'(16'd1),
    parameter logic [WIDTH-1:0] MUL_K = WIDTH'(16'd3),
    parameter logic [WIDTH-1:0] XOR_K = WIDTH'(16'h00FF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0]   r1;
    logic [WIDTH-1:0]   r2;
    logic [WIDTH-1:0]   r3;
    logic [WIDTH-1:0]   r4;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   product_sat;

    // The product is formed at double width so that no overflow is lost
    // before the saturation decision. Any set bit in the upper half means
    // the true value does not fit in WIDTH bits, so the result clips to
    // all-ones; otherwise the lower half is exact.
    always_comb begin
        product     = {{WIDTH{1'b0}}, r2} * {{WIDTH{1'b0}}, MUL_K};
        product_sat = product[WIDTH-1:0];
        if (|product[2*WIDTH-1:WIDTH]) begin
            product_sat = {WIDTH{1'b1}};
        end
    end

    // All four stages share one reset so nothing stale survives a reset,
    // even mid-stream. After release, the zeros left behind flow through
    // the stages like ordinary data. The stage-2 add keeps only WIDTH bits,
    // so the carry out of the top bit is dropped.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
            r4 <= '0;
        end else begin
            r1 <= in_data;
            r2 <= r1 + ADD_K;
            r3 <= product_sat;
            r4 <= r3 ^ XOR_K;
        end
    end

    assign out_data = r4;

endmodule

// File: tb/tb_pipeline_datapath.sv
// ---------------------------------------------------------------------------
// tb_pipeline_datapath
//
// Directed bench for pipeline_datapath. The stimulus is one linear sequence
// of steps: reset hold, post-reset flush, a directed stream with wrap and
// saturation boundaries, a random stream against a reference model, and a
// reset applied mid-stream.
// ---------------------------------------------------------------------------
module tb_pipeline_datapath;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic [15:0] out_data;

    int compared;
    int mismatched;

    // Expected values waiting for their sample to reach out_data, plus a
    // name for each one to use in failure messages.
    logic [15:0] exp_q[$];
    string       tag_q[$];

    pipeline_datapath dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for one sample, written as plain integer arithmetic:
    // add one with wrap, multiply by three, clip at 0xFFFF, then flip the
    // low byte.
    function automatic logic [15:0] ref_model(input logic [15:0] x);
        int s;
        int p;
        s = (int'(x) + 1) % 65536;
        p = s * 3;
        if (p > 65535) begin
            p = 65535;
        end
        return 16'(p) ^ 16'h00FF;
    endfunction

    // Compare out_data against one expected value and keep the counts.
    task automatic checkOutput(input string tag, input logic [15:0] expected);
        compared++;
        assert (out_data === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: out_data=0x%04h expected=0x%04h", tag, out_data, expected);
        end
    endtask

    // Present one sample, let one rising edge pass, and sample 1 ns later.
    task automatic driveCycle(input logic [15:0] val);
        in_data = val;
        @(posedge clk);
        #1;
    endtask

    // Present one sample and queue its expected result. After the edge,
    // out_data holds the result of the sample queued four cycles earlier,
    // so a comparison happens as soon as four results are waiting.
    task automatic applyStimulus(input logic [15:0] val, input logic [15:0] expected,
                                 input string tag);
        driveCycle(val);
        exp_q.push_back(expected);
        tag_q.push_back(tag);
        if (exp_q.size() == 4) begin
            checkOutput(tag_q.pop_front(), exp_q.pop_front());
        end
    endtask

    initial begin
        logic [15:0] rnd;

        compared   = 0;
        mismatched = 0;

        // Hold reset for two clocks with a nonzero input; the output must
        // stay at zero on each edge and between edges.
        rst_n   = 1'b1;
        in_data = 16'h1234;
        #1;
        checkOutput("reset_t1", 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("reset_edge1", 16'h0000);
        #3;
        checkOutput("reset_mid", 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("reset_edge2", 16'h0000);

        // Release between edges and hold the input at zero. The first
        // capture happens on the next edge.
        rst_n   = 1'b0;
        in_data = 16'h0000;
        #2;
        checkOutput("release_idle", 16'h0000);
        driveCycle(16'h0000);
        checkOutput("flush_edge1", 16'h00FF);
        driveCycle(16'h0000);
        checkOutput("flush_edge2", 16'h00FF);
        driveCycle(16'h0000);
        checkOutput("flush_edge3", 16'h00FC);

        // Directed stream, then the wrap and saturation boundaries, then
        // zeros to drain everything out.
        exp_q.delete();
        tag_q.delete();
        applyStimulus(16'd10,   16'h00DE, "stream_10");
        applyStimulus(16'd20,   16'h00C0, "stream_20");
        applyStimulus(16'd30,   16'h00A2, "stream_30");
        applyStimulus(16'd40,   16'h0084, "stream_40");
        applyStimulus(16'hFFFF, 16'h00FF, "add_wrap");
        applyStimulus(16'h6000, 16'hFF00, "sat_6000");
        applyStimulus(16'h5554, 16'hFF00, "exact_5554");
        applyStimulus(16'h5555, 16'hFF00, "sat_5555");
        applyStimulus(16'h5553, 16'hFF03, "below_5553");
        applyStimulus(16'h0000, 16'h00FC, "zero_after");
        applyStimulus(16'h0001, 16'h00F9, "one");
        applyStimulus(16'h0000, 16'h00FC, "drain_a");
        applyStimulus(16'h0000, 16'h00FC, "drain_b");
        applyStimulus(16'h0000, 16'h00FC, "drain_c");

        // Random stream against the reference model.
        exp_q.delete();
        tag_q.delete();
        for (int i = 0; i < 1000; i++) begin
            rnd = 16'($urandom);
            applyStimulus(rnd, ref_model(rnd), "random");
        end

        // Load four distinctive samples, then reset between edges while
        // they are in flight.
        applyStimulus(16'h0100, ref_model(16'h0100), "inflight_a");
        applyStimulus(16'h0200, ref_model(16'h0200), "inflight_b");
        applyStimulus(16'h0300, ref_model(16'h0300), "inflight_c");
        applyStimulus(16'h0400, ref_model(16'h0400), "inflight_d");
        exp_q.delete();
        tag_q.delete();
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("midreset_now", 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("midreset_edge", 16'h0000);

        // After release, only the reset zeros flow out.
        rst_n   = 1'b0;
        in_data = 16'h0000;
        driveCycle(16'h0000);
        checkOutput("reflush_edge1", 16'h00FF);
        driveCycle(16'h0000);
        checkOutput("reflush_edge2", 16'h00FF);
        driveCycle(16'h0000);
        checkOutput("reflush_edge3", 16'h00FC);
        driveCycle(16'h0000);
        checkOutput("reflush_edge4", 16'h00FC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
